// File: rtl/arc_ctrl_pkg.sv
// arc_ctrl_pkg: opcode/funct codes, ALU op classes and the ID/EX control bundle
package arc_ctrl_pkg;
    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_ADDIU = 6'b001001;
    localparam logic [5:0] OP_SLTI  = 6'b001010;
    localparam logic [5:0] OP_ANDI  = 6'b001100;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_XORI  = 6'b001110;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [2:0] OP_LOAD  = 3'b100;
    localparam logic [2:0] OP_STORE = 3'b101;

    localparam logic [5:0] FN_MFHI  = 6'b010000;
    localparam logic [5:0] FN_MFLO  = 6'b010010;
    localparam logic [3:0] FN_MD    = 4'b0110;

    localparam logic [3:0] OTH_ADD = 4'b0000;
    localparam logic [3:0] OTH_AND = 4'b0001;
    localparam logic [3:0] OTH_OR  = 4'b0010;
    localparam logic [3:0] OTH_XOR = 4'b0011;
    localparam logic [3:0] OTH_SUB = 4'b0101;
    localparam logic [3:0] OTH_SLT = 4'b0110;

    typedef enum logic [1:0] {
        ALU_MEM = 2'b00,
        ALU_BR  = 2'b01,
        ALU_R   = 2'b10,
        ALU_IMM = 2'b11
    } aluop_t;

    typedef enum logic {
        MD_IDLE = 1'b0,
        MD_BUSY = 1'b1
    } md_state_t;

    typedef struct packed {
        logic       regdst;
        logic       branch;
        logic       memread;
        logic       memtoreg;
        logic       memwrite;
        logic       alusrc;
        logic       regwrite;
        aluop_t     aluop;
        logic [3:0] other;
    } ctrl_bundle_t;
endpackage

// File: rtl/ctrl_decode.sv
// ctrl_decode: combinational opcode/funct to control bundle, illegal flag and HI/LO usage
import arc_ctrl_pkg::*;

module ctrl_decode (
    input  logic [5:0]   opcode,
    input  logic [5:0]   funct,
    output ctrl_bundle_t ctl,
    output logic         illegal,
    output logic         md_op,
    output logic         hilo_use
);
    logic rtype;
    assign rtype    = opcode == OP_RTYPE;
    assign md_op    = rtype & (funct[5:2] == FN_MD);
    assign hilo_use = md_op | (rtype & (funct == FN_MFHI | funct == FN_MFLO));

    always_comb begin
        ctl = '0;
        illegal = 1'b0;
        case (opcode)
            OP_RTYPE: begin
                ctl.regdst = 1'b1;
                ctl.regwrite = 1'b1;
                ctl.aluop = ALU_R;
            end
            OP_ADDI, OP_ADDIU, OP_ANDI, OP_ORI, OP_XORI, OP_SLTI: begin
                ctl.regwrite = 1'b1;
                ctl.alusrc = 1'b1;
                ctl.aluop = ALU_IMM;
                ctl.other = opcode == OP_ANDI ? OTH_AND :
                            opcode == OP_ORI  ? OTH_OR  :
                            opcode == OP_XORI ? OTH_XOR :
                            opcode == OP_SLTI ? OTH_SLT : OTH_ADD;
            end
            OP_BEQ: begin
                ctl.branch = 1'b1;
                ctl.aluop = ALU_BR;
            end
            OP_BNE: begin
                ctl.branch = 1'b1;
                ctl.aluop = ALU_IMM;
                ctl.other = OTH_SUB;
            end
            default: begin
                if (opcode[5:3] == OP_LOAD) begin
                    ctl.regwrite = 1'b1;
                    ctl.alusrc = 1'b1;
                    ctl.memread = 1'b1;
                    ctl.memtoreg = 1'b1;
                end else if (opcode[5:3] == OP_STORE) begin
                    ctl.alusrc = 1'b1;
                    ctl.memwrite = 1'b1;
                end else begin
                    illegal = 1'b1;
                end
            end
        endcase
    end
endmodule

// File: rtl/ctrl_pipe.sv
// ctrl_pipe: ID/EX control register with stall/flush bubbles and MULT/DIV HI/LO occupancy tracking
import arc_ctrl_pkg::*;

module ctrl_pipe #(
    parameter int OTHER_W  = 4,
    parameter int MULT_LAT = 4,
    parameter int DIV_LAT  = 32,
    parameter int CNT_W    = 6
) (
    input  logic               i_clk,
    input  logic               i_rst,
    input  logic               i_ctl_valid,
    input  logic [5:0]         i_ctl_opcode,
    input  logic [5:0]         i_ctl_funct,
    input  logic               i_ctl_stall,
    input  logic               i_ctl_flush,
    output logic               o_ctl_regdst,
    output logic               o_ctl_branch,
    output logic               o_ctl_memread,
    output logic               o_ctl_memtoreg,
    output logic               o_ctl_memwrite,
    output logic               o_ctl_alusrc,
    output logic               o_ctl_regwrite,
    output logic [1:0]         o_ctl_aluop,
    output logic [OTHER_W-1:0] o_ctl_other,
    output logic               o_ctl_valid,
    output logic               o_ctl_illegal,
    output logic               o_ctl_md_start,
    output logic               o_ctl_hold_id,
    output logic               o_ctl_md_busy
);
    ctrl_bundle_t     dec, ex_q;
    logic             dec_illegal, md_op, hilo_use, md_stall, issue;
    logic [CNT_W-1:0] cnt, lat;
    md_state_t        state;

    ctrl_decode u_decode (
        .opcode   (i_ctl_opcode),
        .funct    (i_ctl_funct),
        .ctl      (dec),
        .illegal  (dec_illegal),
        .md_op    (md_op),
        .hilo_use (hilo_use)
    );

    assign md_stall      = i_ctl_valid & hilo_use & o_ctl_md_busy;
    assign o_ctl_hold_id = ~i_rst & ~i_ctl_flush & (i_ctl_stall | md_stall);
    assign issue         = i_ctl_valid & ~i_ctl_flush & ~i_ctl_stall & ~md_stall;
    assign lat           = i_ctl_funct[1] ? CNT_W'(DIV_LAT) : CNT_W'(MULT_LAT);

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            ex_q <= '0;
            o_ctl_valid <= 1'b0;
            o_ctl_illegal <= 1'b0;
            o_ctl_md_start <= 1'b0;
            o_ctl_md_busy <= 1'b0;
            cnt <= '0;
            state <= MD_IDLE;
        end else begin
            ex_q <= issue ? dec : ctrl_bundle_t'('0);
            o_ctl_valid <= issue;
            o_ctl_illegal <= issue & dec_illegal;
            o_ctl_md_start <= issue & md_op;
            if (state == MD_IDLE) begin
                if (issue & md_op) begin
                    state <= MD_BUSY;
                    cnt <= lat;
                    o_ctl_md_busy <= 1'b1;
                end
            end else begin
                cnt <= cnt - 1'b1;
                if (cnt == CNT_W'(1)) begin
                    state <= MD_IDLE;
                    o_ctl_md_busy <= 1'b0;
                end
            end
        end
    end

    assign o_ctl_regdst   = ex_q.regdst;
    assign o_ctl_branch   = ex_q.branch;
    assign o_ctl_memread  = ex_q.memread;
    assign o_ctl_memtoreg = ex_q.memtoreg;
    assign o_ctl_memwrite = ex_q.memwrite;
    assign o_ctl_alusrc   = ex_q.alusrc;
    assign o_ctl_regwrite = ex_q.regwrite;
    assign o_ctl_aluop    = ex_q.aluop;
    assign o_ctl_other    = OTHER_W'(ex_q.other);
endmodule

// File: tb/tb_ctrl_pipe.sv
// tb_ctrl_pipe: directed plus random stimulus against a table-driven reference model of ctrl_pipe
module tb_ctrl_pipe;
    localparam int MULT_LAT = 4;
    localparam int DIV_LAT  = 32;

    logic       i_clk = 1'b0;
    logic       i_rst = 1'b1;
    logic       i_ctl_valid = 1'b0;
    logic [5:0] i_ctl_opcode = '0;
    logic [5:0] i_ctl_funct = '0;
    logic       i_ctl_stall = 1'b0;
    logic       i_ctl_flush = 1'b0;
    logic       o_ctl_regdst, o_ctl_branch, o_ctl_memread, o_ctl_memtoreg;
    logic       o_ctl_memwrite, o_ctl_alusrc, o_ctl_regwrite;
    logic [1:0] o_ctl_aluop;
    logic [3:0] o_ctl_other;
    logic       o_ctl_valid, o_ctl_illegal, o_ctl_md_start, o_ctl_hold_id, o_ctl_md_busy;

    int checks = 0;
    int errors = 0;
    logic [12:0] exp_bundle = '0;
    logic exp_valid = 1'b0, exp_ill = 1'b0, exp_start = 1'b0, last_hold = 1'b0;
    int busy_left = 0;

    ctrl_pipe #(.OTHER_W(4), .MULT_LAT(MULT_LAT), .DIV_LAT(DIV_LAT), .CNT_W(6)) dut (
        .i_clk(i_clk), .i_rst(i_rst), .i_ctl_valid(i_ctl_valid),
        .i_ctl_opcode(i_ctl_opcode), .i_ctl_funct(i_ctl_funct),
        .i_ctl_stall(i_ctl_stall), .i_ctl_flush(i_ctl_flush),
        .o_ctl_regdst(o_ctl_regdst), .o_ctl_branch(o_ctl_branch),
        .o_ctl_memread(o_ctl_memread), .o_ctl_memtoreg(o_ctl_memtoreg),
        .o_ctl_memwrite(o_ctl_memwrite), .o_ctl_alusrc(o_ctl_alusrc),
        .o_ctl_regwrite(o_ctl_regwrite), .o_ctl_aluop(o_ctl_aluop),
        .o_ctl_other(o_ctl_other), .o_ctl_valid(o_ctl_valid),
        .o_ctl_illegal(o_ctl_illegal), .o_ctl_md_start(o_ctl_md_start),
        .o_ctl_hold_id(o_ctl_hold_id), .o_ctl_md_busy(o_ctl_md_busy)
    );

    always #5 i_clk = ~i_clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h exp %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // {illegal, regdst, branch, memread, memtoreg, memwrite, alusrc, regwrite, aluop[1:0], other[3:0]}
    function automatic logic [13:0] ref_dec(input logic [5:0] op);
        logic [13:0] r;
        if (op == 6'o00) r = {1'b0, 7'b1000001, 2'b10, 4'h0};
        else if (op == 6'o10 || op == 6'o11) r = {1'b0, 7'b0000011, 2'b11, 4'h0};
        else if (op == 6'o14) r = {1'b0, 7'b0000011, 2'b11, 4'h1};
        else if (op == 6'o15) r = {1'b0, 7'b0000011, 2'b11, 4'h2};
        else if (op == 6'o16) r = {1'b0, 7'b0000011, 2'b11, 4'h3};
        else if (op == 6'o12) r = {1'b0, 7'b0000011, 2'b11, 4'h6};
        else if (op[5:3] == 3'b100) r = {1'b0, 7'b0011011, 2'b00, 4'h0};
        else if (op[5:3] == 3'b101) r = {1'b0, 7'b0000110, 2'b00, 4'h0};
        else if (op == 6'o04) r = {1'b0, 7'b0100000, 2'b01, 4'h0};
        else if (op == 6'o05) r = {1'b0, 7'b0100000, 2'b11, 4'h5};
        else r = {1'b1, 13'b0};
        return r;
    endfunction

    task automatic check_outputs();
        check("bundle", {o_ctl_regdst, o_ctl_branch, o_ctl_memread, o_ctl_memtoreg, o_ctl_memwrite,
                         o_ctl_alusrc, o_ctl_regwrite, o_ctl_aluop, o_ctl_other}, exp_bundle);
        check("valid", o_ctl_valid, exp_valid);
        check("illegal", o_ctl_illegal, exp_ill);
        check("md_start", o_ctl_md_start, exp_start);
        check("md_busy", o_ctl_md_busy, busy_left > 0);
    endtask

    task automatic model_reset();
        exp_bundle = '0;
        exp_valid = 1'b0;
        exp_ill = 1'b0;
        exp_start = 1'b0;
        busy_left = 0;
    endtask

    task automatic step(input logic v, input logic [5:0] op, input logic [5:0] fn,
                        input logic st, input logic fl);
        logic [13:0] d;
        logic md, hilo, busy_now, iss;
        i_ctl_valid = v;
        i_ctl_opcode = op;
        i_ctl_funct = fn;
        i_ctl_stall = st;
        i_ctl_flush = fl;
        #1;
        d = ref_dec(op);
        md = op == 6'o00 && fn >= 6'h18 && fn <= 6'h1b;
        hilo = md || (op == 6'o00 && (fn == 6'h10 || fn == 6'h12));
        busy_now = busy_left > 0;
        last_hold = !fl && (st || (v && hilo && busy_now));
        check("hold_id", o_ctl_hold_id, last_hold);
        iss = v && !fl && !st && !(hilo && busy_now);
        exp_bundle = iss ? d[12:0] : 13'b0;
        exp_valid = iss;
        exp_ill = iss && d[13];
        exp_start = iss && md;
        if (busy_now) busy_left--;
        else if (iss && md) busy_left = fn[1] ? DIV_LAT : MULT_LAT;
        @(negedge i_clk);
        check_outputs();
    endtask

    initial begin
        int waited;
        logic [5:0] ops [15];
        logic [5:0] fns [7];
        ops = '{6'o00, 6'o10, 6'o11, 6'o14, 6'o15, 6'o16, 6'o12, 6'h23, 6'h20,
                6'h2b, 6'h28, 6'o04, 6'o05, 6'h3f, 6'o00};
        fns = '{6'h18, 6'h19, 6'h1a, 6'h1b, 6'h10, 6'h12, 6'h20};
        repeat (2) @(negedge i_clk);
        model_reset();
        check_outputs();
        check("hold_in_reset", o_ctl_hold_id, 1'b0);
        i_rst = 1'b0;

        step(1, 6'o00, 6'h18, 0, 0);
        step(0, 6'o00, 6'h00, 0, 0);
        i_ctl_stall = 1'b1;
        #1 i_rst = 1'b1;
        #1;
        model_reset();
        check_outputs();
        check("hold_in_reset", o_ctl_hold_id, 1'b0);
        @(negedge i_clk);
        i_rst = 1'b0;
        step(1, 6'o10, 6'h00, 0, 0);
        step(1, 6'h23, 6'h00, 0, 0);

        step(1, 6'h2b, 6'h00, 1, 0);
        step(1, 6'h2b, 6'h00, 1, 0);
        step(1, 6'h2b, 6'h00, 0, 0);

        step(1, 6'o00, 6'h18, 0, 0);
        waited = 0;
        do begin
            step(1, 6'o00, 6'h10, 0, 0);
            if (last_hold) waited++;
        end while (last_hold && waited < 50);
        check("mfhi_wait", waited, MULT_LAT);

        step(1, 6'o05, 6'h00, 1, 1);
        step(1, 6'o05, 6'h00, 0, 0);
        step(1, 6'h3f, 6'h00, 0, 0);
        step(0, 6'h3f, 6'h00, 0, 0);

        for (int i = 0; i < 3000; i++) begin
            logic [5:0] op, fn;
            op = $urandom_range(0, 15) == 15 ? 6'($urandom) : ops[$urandom_range(0, 14)];
            fn = $urandom_range(0, 7) == 7 ? 6'($urandom) : fns[$urandom_range(0, 6)];
            step($urandom_range(0, 99) < 85, op, fn,
                 $urandom_range(0, 99) < 15, $urandom_range(0, 99) < 10);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
